// File: rtl/dfr_readout_if.sv
// Bundle of the readout layer's stream, weight-write and result signals.
// The host/reservoir side uses the master view, the readout uses the slave view.
interface dfr_readout_if #(
    parameter int VIRTUAL_NODES = 10,
    parameter int DATA_WIDTH    = 32
);
    localparam int ADDR_W = $clog2(VIRTUAL_NODES + 1);
    localparam int IDX_W  = $clog2(VIRTUAL_NODES);

    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic                  sync;
    logic                  w_we;
    logic [ADDR_W-1:0]     w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic [IDX_W-1:0]      node_idx;

    modport master (
        output din, din_valid, sync, w_we, w_addr, w_data,
        input  dout, dout_valid, node_idx
    );

    modport slave (
        input  din, din_valid, sync, w_we, w_addr, w_data,
        output dout, dout_valid, node_idx
    );
endinterface

// File: rtl/dfr_readout.sv
// Delayed-feedback reservoir readout: per-node weighted sum over one frame, saturated result.
// Optional bias register enabled by defining READOUT_BIAS_EN.
module dfr_readout #(
    parameter int VIRTUAL_NODES = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int FRAC_BITS     = 16
) (
    input  logic           clk,
    input  logic           rst,
    dfr_readout_if.slave   bus
);
    localparam int ADDR_W = $clog2(VIRTUAL_NODES + 1);
    localparam int IDX_W  = $clog2(VIRTUAL_NODES);
    localparam int PW     = 2 * DATA_WIDTH;
    localparam int AW     = PW + $clog2(VIRTUAL_NODES) + 1;

    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [DATA_WIDTH-1:0] weights [VIRTUAL_NODES];
    logic        [IDX_W-1:0]      idx_eff;
    logic signed [PW-1:0]         din_x, w_x, prod_c;

    logic                         s1_valid, s1_first, s1_last;
    logic signed [PW-1:0]         s1_prod;
    logic signed [AW-1:0]         acc, acc_next;
    logic                         s2_done;
    logic signed [AW-1:0]         bias_term, sum_b, shifted;
    logic        [DATA_WIDTH-1:0] sat;

    // NOTE: the weight file is reset explicitly, so after reset every weight reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VIRTUAL_NODES; i++) weights[i] <= '0;
        end else if (bus.w_we) begin
            for (int i = 0; i < VIRTUAL_NODES; i++)
                if (bus.w_addr == ADDR_W'(i)) weights[i] <= bus.w_data;
        end
    end

`ifdef READOUT_BIAS_EN
    logic signed [DATA_WIDTH-1:0] bias;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bias <= '0;
        else if (bus.w_we && bus.w_addr == ADDR_W'(VIRTUAL_NODES))
            bias <= bus.w_data;
    end

    assign bias_term = {{(AW-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias} <<< FRAC_BITS;
`else
    assign bias_term = '0;
`endif

    // A sync beat is node 0 of the new frame, so it must see weight 0 and restart the count.
    assign idx_eff = bus.sync ? '0 : bus.node_idx;
    assign din_x   = {{DATA_WIDTH{bus.din[DATA_WIDTH-1]}}, bus.din};
    assign w_x     = {{DATA_WIDTH{weights[idx_eff][DATA_WIDTH-1]}}, weights[idx_eff]};
    assign prod_c  = din_x * w_x;

    // NOTE: all state below uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.node_idx <= '0;
        end else if (bus.din_valid) begin
            bus.node_idx <= (idx_eff == IDX_W'(VIRTUAL_NODES - 1)) ? '0 : idx_eff + 1'b1;
        end else if (bus.sync) begin
            bus.node_idx <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
        end else begin
            s1_valid <= bus.din_valid;
            s1_first <= bus.din_valid && (idx_eff == '0);
            s1_last  <= bus.din_valid && (idx_eff == IDX_W'(VIRTUAL_NODES - 1));
            if (bus.din_valid) s1_prod <= prod_c;
        end
    end

    assign acc_next = (s1_first ? '0 : acc) + {{(AW-PW){s1_prod[PW-1]}}, s1_prod};

    // sync drops whatever product is in flight along with the partial sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            s2_done <= 1'b0;
        end else if (bus.sync) begin
            acc     <= '0;
            s2_done <= 1'b0;
        end else begin
            s2_done <= s1_valid && s1_last;
            if (s1_valid) acc <= acc_next;
        end
    end

    assign sum_b   = acc + bias_term;
    assign shifted = sum_b >>> FRAC_BITS;

    // NOTE: sat gets a default first so the combinational block cannot infer a latch.
    always_comb begin
        sat = shifted[DATA_WIDTH-1:0];
        if (shifted > SAT_MAX)
            sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN)
            sat = SAT_MIN[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
        end else begin
            bus.dout_valid <= s2_done && !bus.sync;
            if (s2_done && !bus.sync) bus.dout <= sat;
        end
    end
endmodule

// File: tb/tb_dfr_readout.sv
// Self-checking bench for dfr_readout: directed frames plus randomized frames
// compared against a frame-level arithmetic model.
module tb_dfr_readout;
    localparam int VN = 10;
    localparam int DW = 32;
    localparam int FB = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dfr_readout_if #(.VIRTUAL_NODES(VN), .DATA_WIDTH(DW)) bus ();

    dfr_readout #(.VIRTUAL_NODES(VN), .DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int pulse_count = 0;

    // Reference model: frame-level weighted sum with wide plain arithmetic.
    typedef struct {
        int          due;
        logic [31:0] val;
    } res_t;

    logic signed [31:0]  mw [VN];
    logic signed [31:0]  mbias;
    int                  frame_cnt;
    logic signed [127:0] frame_sum;
    res_t                pending [$];
    logic [31:0]         exp_dout;
    logic                exp_valid;

    function automatic logic [31:0] reduce(input logic signed [127:0] s);
        logic signed [127:0] q, lim_hi, lim_lo;
        q      = s >>> FB;
        lim_hi = 128'sh7FFFFFFF;
        lim_lo = -lim_hi - 1;
        if (q > lim_hi) return 32'h7FFFFFFF;
        if (q < lim_lo) return 32'h80000000;
        return q[31:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < VN; i++) mw[i] = '0;
        mbias     = '0;
        frame_cnt = 0;
        frame_sum = '0;
        pending.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
    endtask

    task automatic model_edge();
        longint p;
        logic signed [127:0] s;
        if (rst) begin
            model_reset();
        end else begin
            if (bus.sync) begin
                frame_cnt = 0;
                frame_sum = '0;
                pending.delete();
            end
            if (bus.din_valid) begin
                p = longint'($signed(bus.din)) * longint'(mw[frame_cnt]);
                frame_sum = frame_sum + 128'(p);
                frame_cnt++;
                if (frame_cnt == VN) begin
                    s = frame_sum + (128'(mbias) <<< FB);
                    pending.push_back('{cycle + 2, reduce(s)});
                    frame_cnt = 0;
                    frame_sum = '0;
                end
            end
            if (bus.w_we) begin
                if (bus.w_addr < VN) mw[bus.w_addr] = bus.w_data;
`ifdef READOUT_BIAS_EN
                else if (bus.w_addr == VN) mbias = bus.w_data;
`endif
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cycle++;
        model_edge();
        #1;
        exp_valid = 1'b0;
        if (pending.size() > 0 && pending[0].due == cycle) begin
            exp_valid = 1'b1;
            exp_dout  = pending[0].val;
            void'(pending.pop_front());
        end
        if (bus.dout_valid === 1'b1) pulse_count++;
        check("dout_valid", 32'(bus.dout_valid), 32'(exp_valid));
        check("dout", bus.dout, exp_dout);
        check("node_idx", 32'(bus.node_idx), frame_cnt);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic beat(input logic [31:0] d);
        bus.din       = d;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
    endtask

    task automatic frame(input logic [31:0] d);
        repeat (VN) beat(d);
    endtask

    task automatic write_w(input int addr, input logic [31:0] v);
        bus.w_we   = 1'b1;
        bus.w_addr = 4'(addr);
        bus.w_data = v;
        tick();
        bus.w_we   = 1'b0;
    endtask

    task automatic load_weights(input logic [31:0] v);
        for (int i = 0; i < VN; i++) write_w(i, v);
    endtask

    // Runs one frame of d and checks value, single pulse, and pulse two edges after the last beat.
    task automatic frame_and_check(input string tag, input logic [31:0] d, input logic [31:0] expv);
        int pulses, pulse_at;
        frame(d);
        pulses   = 0;
        pulse_at = -1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (bus.dout_valid === 1'b1) begin
                pulses++;
                pulse_at = k;
            end
        end
        check({tag, "_value"}, bus.dout, expv);
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_latency"}, pulse_at, 2);
    endtask

    initial begin
        int base;
        logic [31:0] d;

        bus.din = '0; bus.din_valid = 1'b0; bus.sync = 1'b0;
        bus.w_we = 1'b0; bus.w_addr = '0; bus.w_data = '0;
        rst = 1'b1;
        model_reset();
        idle(3);
        check("reset_dout", bus.dout, 32'h0);
        check("reset_node_idx", 32'(bus.node_idx), 32'h0);
        rst = 1'b0;
        idle(2);

        // Unity weights, unity states.
        load_weights(32'h00010000);
        frame_and_check("unity", 32'h00010000, 32'h000A0000);

        // Negative weights.
        load_weights(32'hFFFF0000);
        frame_and_check("neg", 32'h00020000, 32'hFFEC0000);

        // Saturation in both directions.
        load_weights(32'h7FFFFFFF);
        frame_and_check("sat_pos", 32'h7FFFFFFF, 32'h7FFFFFFF);
        frame_and_check("sat_neg", 32'h80000001, 32'h80000000);

        // Gapped frame followed by two back-to-back frames.
        load_weights(32'h00010000);
        base = pulse_count;
        for (int i = 0; i < VN; i++) begin
            beat(32'h00010000);
            idle($urandom_range(0, 3));
        end
        frame(32'h00010000);
        frame(32'h00010000);
        idle(4);
        check("b2b_pulses", pulse_count - base, 3);
        check("b2b_value", bus.dout, 32'h000A0000);

        // Partial frame aborted by sync (idle cycle), then a full frame.
        base = pulse_count;
        repeat (5) beat(32'h00030000);
        bus.sync = 1'b1;
        tick();
        bus.sync = 1'b0;
        frame(32'h00010000);
        idle(4);
        check("sync_pulses", pulse_count - base, 1);
        check("sync_value", bus.dout, 32'h000A0000);

        // sync together with din_valid: that beat is node 0.
        base = pulse_count;
        repeat (5) beat(32'h00050000);
        bus.sync = 1'b1;
        beat(32'h00010000);
        bus.sync = 1'b0;
        repeat (VN - 1) beat(32'h00010000);
        idle(4);
        check("sync_beat_pulses", pulse_count - base, 1);
        check("sync_beat_value", bus.dout, 32'h000A0000);

        // Partial frame aborted by an asynchronous reset.
        repeat (5) beat(32'h00010000);
        rst = 1'b1;
        #1;
        check("async_rst_dout", bus.dout, 32'h0);
        check("async_rst_idx", 32'(bus.node_idx), 32'h0);
        model_reset();
        tick();
        rst = 1'b0;
        base = pulse_count;
        load_weights(32'h00010000);
        frame(32'h00010000);
        idle(4);
        check("rst_pulses", pulse_count - base, 1);
        check("rst_value", bus.dout, 32'h000A0000);

        // Bias register (ignored when the feature is not built in).
        write_w(VN, 32'h00008000);
`ifdef READOUT_BIAS_EN
        frame_and_check("bias", 32'h00010000, 32'h000A8000);
`else
        frame_and_check("bias", 32'h00010000, 32'h000A0000);
`endif

        // Randomized frames with gaps, concurrent weight writes, out-of-range writes.
        for (int i = 0; i < VN; i++) write_w(i, $urandom());
        base = pulse_count;
        for (int f = 0; f < 6; f++) begin
            for (int n = 0; n < VN; n++) begin
                d = $urandom();
                if (f % 2 == 0) d = 32'($signed(d) >>> 12);
                bus.din       = d;
                bus.din_valid = 1'b1;
                if ($urandom_range(0, 3) == 0) begin
                    bus.w_we   = 1'b1;
                    bus.w_addr = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, VN - 1))
                                                              : 4'($urandom_range(VN + 1, 15));
                    bus.w_data = (f % 2 == 0) ? 32'($signed($urandom()) >>> 12) : $urandom();
                end
                tick();
                bus.din_valid = 1'b0;
                bus.w_we      = 1'b0;
                idle($urandom_range(0, 2));
            end
        end
        idle(4);
        check("rand_pulses", pulse_count - base, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
